// File: rtl/conv_layer_sched.sv
// Layer-pass sequencer for the conv engine: loads weights and bias, streams the input
// feature map, and writes conv results to the output buffer under backpressure.
module conv_layer_sched #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned RESULT_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              cfg_input_dim,
    input  logic [1:0]              cfg_window_dim,
    input  logic                    cfg_stride,
    input  logic [ADDR_WIDTH-1:0]   cfg_weight_base,
    input  logic [ADDR_WIDTH-1:0]   cfg_bias_base,
    input  logic [ADDR_WIDTH-1:0]   cfg_pixel_base,
    input  logic [ADDR_WIDTH-1:0]   cfg_out_base,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    conv_weights_valid,
    output logic                    conv_bias_valid,
    output logic                    conv_new_data_valid,
    output logic [DATA_WIDTH:0]     conv_data,
    output logic                    conv_stride,
    output logic [7:0]              conv_input_dim,
    output logic [1:0]              conv_window_dim,
    input  logic [RESULT_WIDTH-1:0] conv_result,
    input  logic                    conv_result_valid,
    output logic                    conv_out_accepting,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [RESULT_WIDTH-1:0] wr_data,
    input  logic                    wr_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadB,
        StStream,
        StDrain,
        StFin,
        StErr
    } state_e;

    typedef enum logic [1:0] {
        KindNone,
        KindWeight,
        KindBias,
        KindPixel
    } kind_e;

    state_e state_q, state_d;
    kind_e  rd_kind, kind_q;

    logic [15:0] rd_idx_q, rd_idx_d;
    logic [15:0] res_cnt_q;

    // Latched configuration and derived per-pass totals
    logic [7:0]            input_dim_q;
    logic [1:0]            window_dim_q;
    logic                  stride_q;
    logic [ADDR_WIDTH-1:0] weight_base_q;
    logic [ADDR_WIDTH-1:0] bias_base_q;
    logic [ADDR_WIDTH-1:0] pixel_base_q;
    logic [ADDR_WIDTH-1:0] out_base_q;
    logic [3:0]            weight_total_q;
    logic [15:0]           pixel_total_q;
    logic [15:0]           result_total_q;

    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [RESULT_WIDTH-1:0] wr_data_q;

    logic        start_accept;
    logic        cfg_ok;
    logic [7:0]  span;
    logic [7:0]  out_dim;
    logic        weight_last;
    logic        pixel_last;
    logic        result_phase;
    logic        capture;

    assign start_accept = (state_q == StIdle) && start;

    assign cfg_ok  = (cfg_window_dim != 2'd0) && ({6'd0, cfg_window_dim} <= cfg_input_dim);
    assign span    = cfg_input_dim - {6'd0, cfg_window_dim};
    assign out_dim = cfg_stride ? ({1'b0, span[7:1]} + 8'd1) : (span + 8'd1);

    assign weight_last = (rd_idx_q + 16'd1) == {12'd0, weight_total_q};
    assign pixel_last  = (rd_idx_q + 16'd1) == pixel_total_q;

    assign result_phase       = (state_q == StStream) || (state_q == StDrain);
    assign conv_out_accepting = result_phase && wr_ready;
    // Results beyond the expected count are silently dropped
    assign capture = conv_result_valid && conv_out_accepting && (res_cnt_q < result_total_q);

    always_comb begin
        state_d = state_q;
        rd_idx_d = rd_idx_q;
        rd_en = 1'b0;
        rd_addr = '0;
        rd_kind = KindNone;
        busy = 1'b0;
        done = 1'b0;
        err = 1'b0;
        unique case (state_q)
            StIdle: begin
                rd_idx_d = '0;
                if (start) begin
                    state_d = cfg_ok ? StLoadW : StErr;
                end
            end
            StLoadW: begin
                busy = 1'b1;
                rd_en = 1'b1;
                rd_addr = weight_base_q + ADDR_WIDTH'(rd_idx_q);
                rd_kind = KindWeight;
                if (weight_last) begin
                    rd_idx_d = '0;
                    state_d = StLoadB;
                end else begin
                    rd_idx_d = rd_idx_q + 16'd1;
                end
            end
            StLoadB: begin
                busy = 1'b1;
                rd_en = 1'b1;
                rd_addr = bias_base_q;
                rd_kind = KindBias;
                state_d = StStream;
            end
            StStream: begin
                busy = 1'b1;
                // Pixel fetch stalls with the output buffer so results cannot pile up
                if (wr_ready) begin
                    rd_en = 1'b1;
                    rd_addr = pixel_base_q + ADDR_WIDTH'(rd_idx_q);
                    rd_kind = KindPixel;
                    if (pixel_last) begin
                        rd_idx_d = '0;
                        state_d = StDrain;
                    end else begin
                        rd_idx_d = rd_idx_q + 16'd1;
                    end
                end
            end
            StDrain: begin
                busy = 1'b1;
                if ((res_cnt_q == result_total_q) && !wr_en_q) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                done = 1'b1;
                err = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            rd_idx_q <= '0;
            kind_q <= KindNone;
        end else begin
            state_q <= state_d;
            rd_idx_q <= rd_idx_d;
            // Steering is decided at issue time, so it survives the state advancing
            kind_q <= rd_kind;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            input_dim_q <= '0;
            window_dim_q <= '0;
            stride_q <= 1'b0;
            weight_base_q <= '0;
            bias_base_q <= '0;
            pixel_base_q <= '0;
            out_base_q <= '0;
            weight_total_q <= '0;
            pixel_total_q <= '0;
            result_total_q <= '0;
        end else if (start_accept) begin
            input_dim_q <= cfg_input_dim;
            window_dim_q <= cfg_window_dim;
            stride_q <= cfg_stride;
            weight_base_q <= cfg_weight_base;
            bias_base_q <= cfg_bias_base;
            pixel_base_q <= cfg_pixel_base;
            out_base_q <= cfg_out_base;
            weight_total_q <= 4'(cfg_window_dim) * 4'(cfg_window_dim);
            pixel_total_q <= 16'(cfg_input_dim) * 16'(cfg_input_dim);
            result_total_q <= 16'(out_dim) * 16'(out_dim);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            res_cnt_q <= '0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= capture;
            if (start_accept) begin
                res_cnt_q <= '0;
            end else if (capture) begin
                wr_addr_q <= out_base_q + ADDR_WIDTH'(res_cnt_q);
                wr_data_q <= conv_result;
                res_cnt_q <= res_cnt_q + 16'd1;
            end
        end
    end

    assign conv_weights_valid  = (kind_q == KindWeight);
    assign conv_bias_valid     = (kind_q == KindBias);
    assign conv_new_data_valid = (kind_q == KindPixel);
    assign conv_data           = (kind_q != KindNone) ? {1'b0, rd_data} : '0;
    assign conv_stride         = stride_q;
    assign conv_input_dim      = input_dim_q;
    assign conv_window_dim     = window_dim_q;

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: stimulus side pushes expected reads, strobes and writes into
// queues; an independent monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_conv_layer_sched;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int RW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    cfg_input_dim = '0;
    logic [1:0]    cfg_window_dim = '0;
    logic          cfg_stride = 1'b0;
    logic [AW-1:0] cfg_weight_base = '0;
    logic [AW-1:0] cfg_bias_base = '0;
    logic [AW-1:0] cfg_pixel_base = '0;
    logic [AW-1:0] cfg_out_base = '0;
    logic [DW-1:0] rd_data = '0;
    logic [RW-1:0] conv_result = '0;
    logic          conv_result_valid = 1'b0;
    logic          wr_ready = 1'b1;

    logic          busy, done, err, rd_en;
    logic [AW-1:0] rd_addr;
    logic          conv_weights_valid, conv_bias_valid, conv_new_data_valid;
    logic [DW:0]   conv_data;
    logic          conv_stride;
    logic [7:0]    conv_input_dim;
    logic [1:0]    conv_window_dim;
    logic          conv_out_accepting;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;

    conv_layer_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cfg_input_dim(cfg_input_dim), .cfg_window_dim(cfg_window_dim), .cfg_stride(cfg_stride),
        .cfg_weight_base(cfg_weight_base), .cfg_bias_base(cfg_bias_base),
        .cfg_pixel_base(cfg_pixel_base), .cfg_out_base(cfg_out_base),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .conv_weights_valid(conv_weights_valid),
        .conv_bias_valid(conv_bias_valid), .conv_new_data_valid(conv_new_data_valid),
        .conv_data(conv_data), .conv_stride(conv_stride), .conv_input_dim(conv_input_dim),
        .conv_window_dim(conv_window_dim), .conv_result(conv_result),
        .conv_result_valid(conv_result_valid), .conv_out_accepting(conv_out_accepting),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    always #5 clock = ~clock;

    logic [92:0] all_out;
    assign all_out = {busy, done, err, rd_en, rd_addr, conv_weights_valid, conv_bias_valid,
                      conv_new_data_valid, conv_data, conv_stride, conv_input_dim,
                      conv_window_dim, conv_out_accepting, wr_en, wr_addr, wr_data};

    typedef struct {
        logic [AW-1:0] addr;
        int            kind;
    } rd_item_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_item_t;

    rd_item_t      exp_rd[$];
    int            exp_kind[$];
    logic [DW-1:0] exp_byte[$];
    wr_item_t      exp_wr[$];

    int total = 0;
    int bad = 0;

    // Reference model state
    int            m_res_total = 0;
    logic [AW-1:0] m_out_base = '0;
    int            acc_cnt = 0;
    int            emitted = 0;
    int            pix_seen = 0;
    int            ready_mode = 0;
    int            low_left = 0;
    bit            low_done = 1'b0;
    bit            pend = 1'b0;
    logic [DW-1:0] pend_val = '0;

    // Monitor state
    bit mon_en = 1'b0;
    bit pass_active = 1'b0;
    bit loading = 1'b0;
    bit prev_ready = 1'b1;
    int rd_seen = 0;
    int wr_seen = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int pix_rd = 0;
    int low_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic flush();
        exp_rd.delete();
        exp_kind.delete();
        exp_byte.delete();
        exp_wr.delete();
    endtask

    // Expected traffic of a pass computed straight from the layer geometry
    task automatic plan(input int n, input int k, input int s, input logic [AW-1:0] wb,
                        input logic [AW-1:0] bb, input logic [AW-1:0] pb,
                        input logic [AW-1:0] ob);
        rd_item_t r;
        int m;
        acc_cnt = 0;
        emitted = 0;
        pix_seen = 0;
        pix_rd = 0;
        low_cycles = 0;
        low_left = 0;
        low_done = 1'b0;
        m_out_base = ob;
        m_res_total = 0;
        if (k == 0 || k > n) return;
        m = (s != 0) ? (n - k) / 2 + 1 : n - k + 1;
        m_res_total = m * m;
        for (int i = 0; i < k * k; i++) begin
            r.addr = wb + AW'(i);
            r.kind = 1;
            exp_rd.push_back(r);
            exp_kind.push_back(1);
        end
        r.addr = bb;
        r.kind = 2;
        exp_rd.push_back(r);
        exp_kind.push_back(2);
        for (int i = 0; i < n * n; i++) begin
            r.addr = pb + AW'(i);
            r.kind = 3;
            exp_rd.push_back(r);
            exp_kind.push_back(3);
        end
    endtask

    // Memory and conv-engine model driving the DUT inputs
    initial begin
        wr_item_t w;
        logic [DW-1:0] b;
        forever begin
            @(negedge clock);
            if (ready_mode == 1) begin
                wr_ready = ($urandom_range(3) != 0);
            end else if (ready_mode == 2) begin
                if (!low_done && pix_seen >= 20) begin
                    low_left = 10;
                    low_done = 1'b1;
                end
                wr_ready = (low_left == 0);
                if (low_left > 0) low_left--;
            end else begin
                wr_ready = 1'b1;
            end
            #1;
            if (rd_en) begin
                b = 8'($urandom);
                exp_byte.push_back(b);
                pend = 1'b1;
                pend_val = b;
            end
            if (conv_new_data_valid) pix_seen++;
            conv_result = $urandom;
            if (conv_out_accepting) begin
                conv_result_valid = (emitted < pix_seen) && ($urandom_range(1) == 1);
                if (conv_result_valid) begin
                    emitted++;
                    if (acc_cnt < m_res_total) begin
                        w.addr = m_out_base + AW'(acc_cnt);
                        w.data = conv_result;
                        exp_wr.push_back(w);
                        acc_cnt++;
                    end
                end
            end else begin
                // Occasional protocol-violating strobe that must never be captured
                conv_result_valid = ($urandom_range(3) == 0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            rd_data = pend ? pend_val : 8'($urandom);
            pend = 1'b0;
        end
    end

    initial begin
        rd_item_t ri;
        wr_item_t wi;
        int kind_now;
        logic [DW-1:0] b;
        forever begin
            @(negedge clock);
            #2;
            if (mon_en) begin
                check("busy", 64'(busy), 64'(pass_active && !done));
                if (loading || !pass_active || done) check("acc_phase", 64'(conv_out_accepting), 0);
                if (!wr_ready) begin
                    check("stall_acc", 64'(conv_out_accepting), 0);
                    if (!loading) check("stall_rd", 64'(rd_en), 0);
                    if (busy) low_cycles++;
                end
                if (!prev_ready) check("stall_wr", 64'(wr_en), 0);
                prev_ready = wr_ready;
                if (rd_en) begin
                    rd_seen++;
                    if (exp_rd.size() == 0) begin
                        check("rd_unexpected", 64'(rd_addr), 64'hdead);
                    end else begin
                        ri = exp_rd.pop_front();
                        check("rd_addr", 64'(rd_addr), 64'(ri.addr));
                        if (ri.kind == 3) pix_rd++;
                        if (ri.kind == 2) loading = 1'b0;
                    end
                end
                if (conv_weights_valid || conv_bias_valid || conv_new_data_valid) begin
                    unique case ({conv_new_data_valid, conv_bias_valid, conv_weights_valid})
                        3'b001: kind_now = 1;
                        3'b010: kind_now = 2;
                        3'b100: kind_now = 3;
                        default: kind_now = 9;
                    endcase
                    if (exp_kind.size() == 0 || exp_byte.size() == 0) begin
                        check("strobe_unexpected", 64'(kind_now), 0);
                    end else begin
                        check("strobe_kind", 64'(kind_now), 64'(exp_kind.pop_front()));
                        b = exp_byte.pop_front();
                        check("conv_data", 64'(conv_data), 64'({1'b0, b}));
                    end
                end
                if (wr_en) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", 64'(wr_addr), 64'hdead);
                    end else begin
                        wi = exp_wr.pop_front();
                        check("wr_addr", 64'(wr_addr), 64'(wi.addr));
                        check("wr_data", 64'(wr_data), 64'(wi.data));
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (err) err_cnt++;
                    pass_active = 1'b0;
                    loading = 1'b0;
                end
            end
        end
    end

    task automatic recover();
        pass_active = 1'b0;
        loading = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        #3;
        flush();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #3;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("done_timeout", 0, 1);
            recover();
        end
    endtask

    task automatic launch(input int n, input int k, input int s, input int mode,
                          input logic [AW-1:0] wb, input logic [AW-1:0] bb,
                          input logic [AW-1:0] pb, input logic [AW-1:0] ob);
        ready_mode = mode;
        plan(n, k, s, wb, bb, pb, ob);
        @(negedge clock);
        cfg_input_dim = 8'(n);
        cfg_window_dim = 2'(k);
        cfg_stride = s[0];
        cfg_weight_base = wb;
        cfg_bias_base = bb;
        cfg_pixel_base = pb;
        cfg_out_base = ob;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pass_active = 1'b1;
        loading = 1'b1;
    endtask

    task automatic run_pass(input int n, input int k, input int s, input int mode, input bit dbl,
                            input logic [AW-1:0] wb, input logic [AW-1:0] bb,
                            input logic [AW-1:0] pb, input logic [AW-1:0] ob);
        int rd0, wr0, d0, e0;
        rd0 = rd_seen;
        wr0 = wr_seen;
        d0 = done_cnt;
        e0 = err_cnt;
        launch(n, k, s, mode, wb, bb, pb, ob);
        #3;
        check("cfg_dim", 64'({conv_input_dim, conv_window_dim, conv_stride}), 64'({8'(n), 2'(k), s[0]}));
        if (dbl) begin
            @(negedge clock);
            cfg_input_dim = 8'd5;
            cfg_window_dim = 2'd2;
            cfg_stride = ~cfg_stride;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            #3;
            check("cfg_hold", 64'({conv_input_dim, conv_window_dim, conv_stride}), 64'({8'(n), 2'(k), s[0]}));
        end
        wait_done(4000);
        check("done_err", 64'(err), 0);
        repeat (3) @(negedge clock);
        #3;
        check("rd_left", 64'(exp_rd.size()), 0);
        check("strobe_left", 64'(exp_kind.size()), 0);
        check("wr_left", 64'(exp_wr.size()), 0);
        check("rd_count", 64'(rd_seen - rd0), 64'(k * k + 1 + n * n));
        check("wr_count", 64'(wr_seen - wr0), 64'(m_res_total));
        check("done_count", 64'(done_cnt - d0), 1);
        check("err_count", 64'(err_cnt - e0), 0);
        if (mode == 2) check("stall_cycles", 64'(low_cycles), 10);
        flush();
    endtask

    task automatic run_err(input int n, input int k);
        int rd0, wr0, d0, e0;
        rd0 = rd_seen;
        wr0 = wr_seen;
        d0 = done_cnt;
        e0 = err_cnt;
        launch(n, k, 0, 0, 16'h100, 16'h200, 16'h1000, 16'h4000);
        #3;
        check("err_pulse", 64'({done, err}), 64'h3);
        repeat (4) @(negedge clock);
        #3;
        check("err_rd", 64'(rd_seen - rd0), 0);
        check("err_wr", 64'(wr_seen - wr0), 0);
        check("err_done_count", 64'(done_cnt - d0), 1);
        check("err_err_count", 64'(err_cnt - e0), 1);
        flush();
    endtask

    task automatic run_reset_mid();
        int d0;
        bit hit;
        d0 = done_cnt;
        hit = 1'b0;
        launch(14, 3, 0, 0, 16'h100, 16'h200, 16'h1000, 16'h4000);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            #3;
            if (pix_rd >= 50) begin
                hit = 1'b1;
                break;
            end
        end
        check("reset_mid_reached", 64'(hit), 1);
        pass_active = 1'b0;
        loading = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        #3;
        check("reset_mid_zero", 64'(|all_out), 0);
        flush();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #3;
        check("reset_mid_no_done", 64'(done_cnt - d0), 0);
    endtask

    initial begin
        int n, k;
        repeat (3) @(negedge clock);
        #3;
        check("reset_all_zero", 64'(|all_out), 0);
        check("reset_busy_done", 64'({busy, done, err}), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        run_pass(14, 3, 0, 0, 1'b0, 16'h100, 16'h200, 16'h1000, 16'h4000);
        run_pass(14, 3, 1, 0, 1'b0, 16'h100, 16'h200, 16'h1000, 16'h4000);
        run_pass(14, 3, 0, 2, 1'b0, 16'h100, 16'h200, 16'h1000, 16'h4000);
        run_err(14, 0);
        run_err(2, 3);
        run_reset_mid();
        run_pass(14, 3, 0, 0, 1'b0, 16'h100, 16'h200, 16'h1000, 16'h4000);
        run_pass(14, 3, 0, 0, 1'b1, 16'h100, 16'h200, 16'h1000, 16'h4000);
        run_pass(3, 3, 1, 1, 1'b0, 16'h0ff0, 16'h0002, 16'hfff0, 16'h8000);
        for (int i = 0; i < 5; i++) begin
            n = $urandom_range(12, 1);
            k = $urandom_range(3, 1);
            if (k > n) k = n;
            run_pass(n, k, int'($urandom_range(1)), 1, 1'b0, 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
